svi_port_arb: RTL

- Round-robin arbiter and sequencer that shares the producer side of interface I (modport P2: z, y) between N_REQ requesters.
- Each granted requester's operand pair is driven onto u_I.z/u_I.y and held for WAIT_CYCLES cycles.
- The consumer's combinational result (sum of z and y, from the P1 side) is then captured and returned to the owning requester.
- Sits in place of a single fixed P2 driver, between requester logic and the interface instance.

---
 rtl/svi_port_arb_pkg.sv | 16 +
 rtl/svi_port_arb_if.sv | 13 +
 rtl/svi_port_arb_rr_pick.sv | 31 +++
 rtl/svi_port_arb.sv | 120 ++++++++++++
 4 files changed

// File: rtl/svi_port_arb_pkg.sv
// Shared types for the requester-to-interface port arbiter.
// Holds the data width, the sequencer state encoding and the operand type.
// Imported by the interface, the round-robin picker and the arbiter top.
package svi_port_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/svi_port_arb_if.sv
// Operand bus between the producer (P2) and the combinational adder consumer (P1).
// No latency of its own; the values are whatever the producer currently drives.
// No backpressure: the consumer simply reads whatever the producer presents.
interface svi_port_arb_if;
    import svi_port_arb_pkg::*;

    data_t z;
    data_t y;

    modport P1 (input  z, input  y);
    modport P2 (output z, output y);

endinterface

// File: rtl/svi_port_arb_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping upward.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the pick is consumed.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [$clog2(N_REQ)-1:0] o_owner,
    output logic                     o_valid
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset down to the nearest so the closest set bit wins.
    always_comb begin
        o_owner = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = IDX_W'((int'(i_ptr) + i) % N_REQ);
            if (i_req[w_idx]) begin
                o_owner = w_idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/svi_port_arb.sv
// Round-robin arbiter sharing the P2 side of the operand bus between N_REQ requesters.
// Grant at edge k, result captured at edge k+WAIT_CYCLES+1, next grant possible one edge later.
// Requests arriving while busy are ignored; requesters hold i_req until they see o_gnt.
module svi_port_arb
    import svi_port_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                i_clk,
    input  logic                i_arst,
    input  logic [N_REQ-1:0]    i_req,
    input  data_t [N_REQ-1:0]   i_z,
    input  data_t [N_REQ-1:0]   i_y,
    output logic [N_REQ-1:0]    o_gnt,
    svi_port_arb_if.P2          u_I,
    input  data_t               i_sum,
    output logic [N_REQ-1:0]    o_rsp_valid,
    output data_t               o_rsp_data,
    output logic                o_busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    arb_state_t        r_state,   w_state;
    logic [IDX_W-1:0]  r_ptr,     w_ptr;
    logic [IDX_W-1:0]  r_owner,   w_owner;
    logic [CNT_W-1:0]  r_cnt,     w_cnt;
    data_t             r_z,       w_z;
    data_t             r_y,       w_y;
    logic [N_REQ-1:0]  r_gnt,     w_gnt;
    logic [N_REQ-1:0]  r_rsp_vld, w_rsp_vld;
    data_t             r_rsp_dat, w_rsp_dat;

    logic [IDX_W-1:0]  w_pick_owner;
    logic              w_pick_vld;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_owner (w_pick_owner),
        .o_valid (w_pick_vld)
    );

    // State and output registers; reset clears everything including the held operands.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_z       <= '0;
            r_y       <= '0;
            r_gnt     <= '0;
            r_rsp_vld <= '0;
            r_rsp_dat <= '0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_owner   <= w_owner;
            r_cnt     <= w_cnt;
            r_z       <= w_z;
            r_y       <= w_y;
            r_gnt     <= w_gnt;
            r_rsp_vld <= w_rsp_vld;
            r_rsp_dat <= w_rsp_dat;
        end
    end

    // Next-state logic: grant and response are single-cycle pulses, operands and data hold.
    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_owner   = r_owner;
        w_cnt     = r_cnt;
        w_z       = r_z;
        w_y       = r_y;
        w_gnt     = '0;
        w_rsp_vld = '0;
        w_rsp_dat = r_rsp_dat;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_owner = w_pick_owner;
                    w_z     = i_z[w_pick_owner];
                    w_y     = i_y[w_pick_owner];
                    w_gnt   = N_REQ'(1) << w_pick_owner;
                    w_cnt   = '0;
                    w_state = WAIT;
                end
            end
            WAIT: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_rsp_dat = i_sum;
                w_rsp_vld = N_REQ'(1) << r_owner;
                w_ptr     = (r_owner == IDX_LAST) ? '0 : r_owner + 1'b1;
                w_state   = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign u_I.z       = r_z;
    assign u_I.y       = r_y;
    assign o_gnt       = r_gnt;
    assign o_rsp_valid = r_rsp_vld;
    assign o_rsp_data  = r_rsp_dat;
    assign o_busy      = (r_state != IDLE);

endmodule
